// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with per-set MRU-bit pseudo-LRU,
// AXI INCR burst line refill, and a one-set-per-cycle invalidate-all flush.
module icache_nway #(
    parameter int unsigned ADDR_SIZE      = 32,
    parameter int unsigned CACHE_SIZE     = 16384,
    parameter int unsigned BLK_PER_SET    = 2,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned INST_SIZE      = 32
) (
    input  logic                 i_aclk,
    input  logic                 i_areset,
    input  logic                 i_req,
    input  logic [ADDR_SIZE-1:0] i_addr,
    output logic                 o_req_ready,
    output logic                 o_instr_valid,
    output logic [INST_SIZE-1:0] o_instruction,
    output logic                 o_err,
    input  logic                 i_flush,
    output logic                 o_flush_busy,
    output logic                 o_ar_valid,
    input  logic                 i_ar_ready,
    output logic [ADDR_SIZE-1:0] o_ar_addr,
    output logic [7:0]           o_ar_len,
    output logic [2:0]           o_ar_size,
    output logic [1:0]           o_ar_burst,
    input  logic                 i_r_valid,
    output logic                 o_r_ready,
    input  logic [INST_SIZE-1:0] i_r_data,
    input  logic [1:0]           i_r_resp,
    input  logic                 i_r_last
);

    localparam int unsigned BYTES_PER_WORD = INST_SIZE / 8;
    localparam int unsigned OFF_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = $clog2(WORDS_PER_LINE);
    localparam int unsigned LINE_W         = OFF_W + WORD_W;
    localparam int unsigned LINE_BYTES     = WORDS_PER_LINE * BYTES_PER_WORD;
    localparam int unsigned SETS           = CACHE_SIZE / (BLK_PER_SET * LINE_BYTES);
    localparam int unsigned IDX_W          = $clog2(SETS);
    localparam int unsigned TAG_W          = ADDR_SIZE - LINE_W - IDX_W;
    localparam int unsigned WAY_W          = (BLK_PER_SET > 1) ? $clog2(BLK_PER_SET) : 1;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_AR,
        MISS_R,
        RESP,
        FLUSH
    } state_t;

    state_t                 state;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic                   flush_pend;
    logic                   rdy_q;
    logic [IDX_W-1:0]       flush_idx;
    logic [WORD_W-1:0]      beat_cnt;
    logic [WAY_W-1:0]       victim_q;
    logic                   burst_err;
    logic [INST_SIZE-1:0]   word_q;

    logic [BLK_PER_SET-1:0] valid_mem [SETS];
    logic [BLK_PER_SET-1:0] mru_mem   [SETS];
    logic [TAG_W-1:0]       tag_mem   [SETS][BLK_PER_SET];
    logic [INST_SIZE-1:0]   data_mem  [SETS][BLK_PER_SET][WORDS_PER_LINE];

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [WORD_W-1:0]      req_word;
    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [WAY_W-1:0]       victim;
    logic                   beat_last;
    logic                   beat_err;
    logic                   fill_ok;

    assign req_tag  = addr_q[ADDR_SIZE-1 -: TAG_W];
    assign req_idx  = addr_q[LINE_W +: IDX_W];
    assign req_word = addr_q[OFF_W +: WORD_W];

    // A flush request seen this cycle must block acceptance at the same edge.
    assign o_req_ready = rdy_q & ~i_flush;
    assign o_ar_len    = 8'(WORDS_PER_LINE - 1);
    assign o_ar_size   = 3'(OFF_W);
    assign o_ar_burst  = 2'b01;

    assign beat_last = (beat_cnt == LAST_BEAT);
    assign beat_err  = burst_err | (i_r_resp != 2'b00) | (i_r_last != beat_last);
    assign fill_ok   = (state == MISS_R) && i_r_valid && beat_last && !beat_err;

    function automatic logic [BLK_PER_SET-1:0] mru_next(input logic [BLK_PER_SET-1:0] row,
                                                        input logic [WAY_W-1:0] way);
        logic [BLK_PER_SET-1:0] one_hot;
        logic [BLK_PER_SET-1:0] upd;
        one_hot      = '0;
        one_hot[way] = 1'b1;
        upd          = row | one_hot;
        return (&upd) ? one_hot : upd;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = WAY_W'(BLK_PER_SET - 1);
        for (int unsigned w = 0; w < BLK_PER_SET; w++) begin
            if (valid_mem[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            // Ascending scan: the last zero bit found is the highest-index one.
            if (!mru_mem[req_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state         <= IDLE;
            addr_q        <= '0;
            flush_pend    <= 1'b0;
            rdy_q         <= 1'b0;
            flush_idx     <= '0;
            beat_cnt      <= '0;
            victim_q      <= '0;
            burst_err     <= 1'b0;
            word_q        <= '0;
            o_instr_valid <= 1'b0;
            o_instruction <= '0;
            o_err         <= 1'b0;
            o_flush_busy  <= 1'b0;
            o_ar_valid    <= 1'b0;
            o_ar_addr     <= '0;
            o_r_ready     <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                mru_mem[s]   <= '0;
            end
        end else begin
            o_instr_valid <= 1'b0;
            if (i_flush) begin
                flush_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (flush_pend || i_flush) begin
                        state        <= FLUSH;
                        flush_pend   <= 1'b0;
                        flush_idx    <= '0;
                        o_flush_busy <= 1'b1;
                        rdy_q        <= 1'b0;
                    end else if (i_req && rdy_q) begin
                        addr_q <= i_addr;
                        state  <= LOOKUP;
                        rdy_q  <= 1'b0;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        o_instr_valid    <= 1'b1;
                        o_instruction    <= data_mem[req_idx][hit_way][req_word];
                        o_err            <= 1'b0;
                        mru_mem[req_idx] <= mru_next(mru_mem[req_idx], hit_way);
                        state            <= IDLE;
                        rdy_q            <= !(flush_pend || i_flush);
                    end else begin
                        state      <= MISS_AR;
                        o_ar_valid <= 1'b1;
                        o_ar_addr  <= addr_q & ~ADDR_SIZE'(LINE_BYTES - 1);
                        victim_q   <= victim;
                        beat_cnt   <= '0;
                        burst_err  <= 1'b0;
                    end
                end
                MISS_AR: begin
                    if (i_ar_ready) begin
                        o_ar_valid <= 1'b0;
                        o_r_ready  <= 1'b1;
                        state      <= MISS_R;
                    end
                end
                MISS_R: begin
                    if (i_r_valid) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        burst_err <= beat_err;
                        if (beat_cnt == req_word) begin
                            word_q <= i_r_data;
                        end
                        if (beat_last) begin
                            o_r_ready     <= 1'b0;
                            state         <= RESP;
                            o_instr_valid <= 1'b1;
                            o_err         <= beat_err;
                            // The requested word may be arriving on this very beat.
                            o_instruction <= beat_err ? '0 :
                                             ((req_word == LAST_BEAT) ? i_r_data : word_q);
                            if (!beat_err) begin
                                valid_mem[req_idx][victim_q] <= 1'b1;
                                mru_mem[req_idx] <= mru_next(mru_mem[req_idx], victim_q);
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    rdy_q <= !(flush_pend || i_flush);
                end
                FLUSH: begin
                    valid_mem[flush_idx] <= '0;
                    mru_mem[flush_idx]   <= '0;
                    if (flush_idx == IDX_W'(SETS - 1)) begin
                        state        <= IDLE;
                        o_flush_busy <= 1'b0;
                        rdy_q        <= !(flush_pend || i_flush);
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies their contents.
    always_ff @(posedge i_aclk) begin
        if ((state == MISS_R) && i_r_valid) begin
            data_mem[req_idx][victim_q][beat_cnt] <= i_r_data;
        end
        if (fill_ok) begin
            tag_mem[req_idx][victim_q] <= req_tag;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Self-checking bench for icache_nway: vector table of fetches plus hand-built
// flush, flush-during-miss and reset-mid-burst sequences, with a response scoreboard.
module tb_icache_nway;

    localparam logic [31:0] DBASE = 32'h1000_0000;
    localparam int          SETS  = 16384 / (2 * 16);

    logic        clk;
    logic        i_areset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        o_req_ready;
    logic        o_instr_valid;
    logic [31:0] o_instruction;
    logic        o_err;
    logic        i_flush;
    logic        o_flush_busy;
    logic        o_ar_valid;
    logic        i_ar_ready;
    logic [31:0] o_ar_addr;
    logic [7:0]  o_ar_len;
    logic [2:0]  o_ar_size;
    logic [1:0]  o_ar_burst;
    logic        i_r_valid;
    logic        o_r_ready;
    logic [31:0] i_r_data;
    logic [1:0]  i_r_resp;
    logic        i_r_last;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          acc_cyc;
    logic [32:0] sb[$];
    logic [32:0] sb_exp;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        int          err_beat;
        bit          last_bad;
    } vec_t;

    vec_t vecs[18];

    icache_nway #(
        .ADDR_SIZE(32),
        .CACHE_SIZE(16384),
        .BLK_PER_SET(2),
        .WORDS_PER_LINE(4),
        .INST_SIZE(32)
    ) dut (
        .i_aclk(clk),
        .i_areset(i_areset),
        .i_req(i_req),
        .i_addr(i_addr),
        .o_req_ready(o_req_ready),
        .o_instr_valid(o_instr_valid),
        .o_instruction(o_instruction),
        .o_err(o_err),
        .i_flush(i_flush),
        .o_flush_busy(o_flush_busy),
        .o_ar_valid(o_ar_valid),
        .i_ar_ready(i_ar_ready),
        .o_ar_addr(o_ar_addr),
        .o_ar_len(o_ar_len),
        .o_ar_size(o_ar_size),
        .o_ar_burst(o_ar_burst),
        .i_r_valid(i_r_valid),
        .o_r_ready(o_r_ready),
        .i_r_data(i_r_data),
        .i_r_resp(i_r_resp),
        .i_r_last(i_r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, {o_req_ready, o_instr_valid, o_err, o_flush_busy, o_ar_valid, o_r_ready}, 6'b0);
        chk({name, "_ar_addr"}, o_ar_addr, 32'h0);
        chk({name, "_instr"}, o_instruction, 32'h0);
    endtask

    // Response scoreboard: every strobe must match the oldest outstanding fetch.
    always @(negedge clk) begin
        if (!i_areset && o_instr_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {31'h0, o_instr_valid}, 64'h0);
            end else begin
                sb_exp = sb.pop_front();
                chk("resp_err", o_err, sb_exp[32]);
                chk("resp_data", o_instruction, sb_exp[31:0]);
            end
        end
    end

    // Entered and left on a falling edge; acts as the AXI slave for any miss.
    task automatic fetch(input logic [31:0] addr, input bit exp_miss, input int err_beat,
                         input bit last_bad, input int ar_delay, input int flush_beat,
                         input int abort_beat);
        logic [31:0] line;
        bit          exp_err;
        int          n;
        line    = addr & 32'hFFFF_FFF0;
        exp_err = exp_miss && ((err_beat >= 0) || last_bad);
        if (abort_beat < 0) sb.push_back({exp_err, exp_err ? 32'h0 : DBASE + addr});
        i_req  = 1'b1;
        i_addr = addr;
        n = 0;
        while (!o_req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            fail("req_ready_wait");
            i_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        i_req = 1'b0;
        n = 1;
        while (!o_instr_valid && !o_ar_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!o_instr_valid && !o_ar_valid) begin
            fail("lookup_wait");
            return;
        end
        chk("miss", o_ar_valid, exp_miss);
        if (!o_ar_valid) begin
            chk("hit_latency", n, 2);
            return;
        end
        chk("ar_addr", o_ar_addr, line);
        chk("ar_len", o_ar_len, 3);
        chk("ar_size", o_ar_size, 2);
        chk("ar_burst", o_ar_burst, 1);
        for (int d = 0; d < ar_delay; d++) begin
            @(negedge clk);
            chk("ar_hold", {o_ar_valid, o_ar_addr}, {1'b1, line});
        end
        i_ar_ready = 1'b1;
        @(negedge clk);
        i_ar_ready = 1'b0;
        chk("r_phase", {o_ar_valid, o_r_ready}, 2'b01);
        for (int k = 0; k < 4; k++) begin
            if (k == abort_beat) begin
                i_r_valid = 1'b0;
                i_areset  = 1'b1;
                @(negedge clk);
                check_zero("reset_mid_burst");
                i_areset = 1'b0;
                @(negedge clk);
                return;
            end
            chk("r_ready", o_r_ready, 1);
            i_r_valid = 1'b1;
            i_r_data  = DBASE + line + 32'(4 * k);
            i_r_resp  = (k == err_beat) ? 2'b10 : 2'b00;
            i_r_last  = (k == 3) ^ last_bad;
            i_flush   = (k == flush_beat);
            @(negedge clk);
            i_flush = 1'b0;
            chk("busy_in_burst", o_flush_busy, 0);
        end
        i_r_valid = 1'b0;
        i_r_last  = 1'b0;
        i_r_resp  = 2'b00;
        chk("resp_strobe", o_instr_valid, 1);
    endtask

    task automatic count_flush(input string name);
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (o_flush_busy && cnt < 2 * SETS) begin
            if (o_req_ready || o_ar_valid || o_instr_valid) bad++;
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, SETS);
        chk({name, "_quiet"}, bad, 0);
    endtask

    initial begin
        int a1;
        int n;
        vecs[0]  = '{32'h0000_0000, 1, -1, 0};
        vecs[1]  = '{32'h0000_0004, 0, -1, 0};
        vecs[2]  = '{32'h0000_000C, 0, -1, 0};
        vecs[3]  = '{32'h0000_2008, 1, -1, 0};
        vecs[4]  = '{32'h0000_4004, 1, -1, 0};
        vecs[5]  = '{32'h0000_2000, 0, -1, 0};
        vecs[6]  = '{32'h0000_0000, 1, -1, 0};
        vecs[7]  = '{32'h0000_4000, 1, -1, 0};
        vecs[8]  = '{32'h0000_0008, 0, -1, 0};
        vecs[9]  = '{32'h0000_100C, 1, -1, 0};
        vecs[10] = '{32'h0000_1010, 1, -1, 0};
        vecs[11] = '{32'h0000_3000, 1,  2, 0};
        vecs[12] = '{32'h0000_3000, 1, -1, 0};
        vecs[13] = '{32'h0000_3004, 0, -1, 0};
        vecs[14] = '{32'h0000_5008, 1, -1, 1};
        vecs[15] = '{32'h0000_5008, 1, -1, 0};
        vecs[16] = '{32'hFFFF_FFFC, 1, -1, 0};
        vecs[17] = '{32'hFFFF_FFF0, 0, -1, 0};

        i_areset   = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        i_flush    = 1'b0;
        i_ar_ready = 1'b0;
        i_r_valid  = 1'b0;
        i_r_data   = '0;
        i_r_resp   = 2'b00;
        i_r_last   = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        i_areset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            fetch(vecs[i].addr, vecs[i].miss, vecs[i].err_beat, vecs[i].last_bad, i % 3, -1, -1);
        end

        // Back-to-back hits, then flush with a simultaneous request.
        fetch(32'h0000_7000, 1, -1, 0, 0, -1, -1);
        fetch(32'h0000_7004, 0, -1, 0, 0, -1, -1);
        a1 = acc_cyc;
        fetch(32'h0000_7008, 0, -1, 0, 0, -1, -1);
        chk("hit_throughput", acc_cyc - a1, 2);
        n = 0;
        while (!o_req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        i_req   = 1'b1;
        i_addr  = 32'h0000_7004;
        i_flush = 1'b1;
        #1 chk("flush_blocks_req", o_req_ready, 0);
        @(negedge clk);
        i_flush = 1'b0;
        chk("flush_busy_start", o_flush_busy, 1);
        count_flush("flush_cycles");
        i_req = 1'b0;
        fetch(32'h0000_7004, 1, -1, 0, 0, -1, -1);

        // Flush raised mid-burst waits for the refill and response.
        fetch(32'h0000_8000, 1, -1, 0, 0, 1, -1);
        n = 0;
        while (!o_flush_busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("flush_after_miss", o_flush_busy, 1);
        count_flush("deferred_flush_cycles");
        fetch(32'h0000_8000, 1, -1, 0, 0, -1, -1);

        // Reset after two beats leaves nothing valid behind.
        fetch(32'h0000_9000, 1, -1, 0, 0, -1, 2);
        fetch(32'h0000_9000, 1, -1, 0, 1, -1, -1);
        fetch(32'h0000_9004, 0, -1, 0, 0, -1, -1);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
